// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory program
// loader. The state enum also lists CHK and ERR so the encoding does not change
// between builds with and without IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int WIDTH          = 32;
  localparam int ADDR_W         = 7;
  localparam int DEPTH          = 2 ** ADDR_W;
  localparam int BYTES_PER_WORD = WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/imem_program_loader_byte_packer.sv
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
// Each byte lane owns its register, and the lane is selected by the byte
// counter. word_ready flags the cycle in which the final byte of a word is
// accepted. On the following cycle, word holds the complete word.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int BPW = BYTES_PER_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             word_ready,
  output logic [8*BPW-1:0] word
);

  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Byte counter: advances on every accepted byte and wraps after the last lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (byte_valid) begin
      cnt_reg <= (cnt_reg == LAST_BYTE) ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Lane register: captures the byte while the counter points at this lane.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (clear) begin
          lane_reg <= '0;
        end else if (byte_valid && (cnt_reg == CNT_W'(gi))) begin
          lane_reg <= byte_data;
        end
      end

      assign word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  assign word_ready = byte_valid && (cnt_reg == LAST_BYTE);

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time program loader placed in front of the single-cycle CPU.
// The loader packs an incoming byte stream into instruction words, writes them
// to the instruction memory and then pulses cpu_start once the image is
// resident.
// Optional feature: when IMEM_LOADER_CHECKSUM_EN is defined, the stream carries
// a trailing byte. That byte must equal the 8-bit modular sum of the data
// bytes. A mismatch parks the loader in ERR with err high and no cpu_start.
module imem_program_loader #(
  parameter int WIDTH  = imem_loader_pkg::WIDTH,
  parameter int ADDR_W = imem_loader_pkg::ADDR_W,
  parameter int DEPTH  = imem_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_adr,
  output logic [WIDTH-1:0]  imem_wd,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import imem_loader_pkg::*;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_RECV  = RECV;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_DONE  = DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = CHK;
  localparam logic [2:0] S_ERR   = ERR;
  // After the last word the trailer byte is still outstanding.
  localparam logic [2:0] S_AFTER = S_CHK;
`else
  localparam logic [2:0] S_AFTER = S_DONE;
`endif

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] adr_hold_reg;
  logic [WIDTH-1:0]  wd_hold_reg;

  logic              accept;
  logic              load_go;
  logic              data_byte;
  logic              last_word;
  logic [ADDR_W:0]   len_sat;
  logic              word_ready;
  logic [WIDTH-1:0]  packed_word;

  assign accept    = in_valid && in_ready;
  assign load_go   = (state_reg == S_IDLE) && load_req;
  assign data_byte = accept && (state_reg == S_RECV);
  assign len_sat   = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
  // ptr is one short of the count; compare in the wider length domain so that
  // a full-depth image finishes at ptr = DEPTH-1.
  assign last_word = (({1'b0, ptr_reg} + (ADDR_W + 1)'(1)) == len_reg);

  byte_packer #(
    .BPW(WIDTH / 8)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_go),
    .byte_valid(data_byte),
    .byte_data (in_data),
    .word_ready(word_ready),
    .word      (packed_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;

  // Running modular sum of data bytes; the trailer itself is not included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg <= '0;
    end else if (load_go) begin
      sum_reg <= '0;
    end else if (data_byte) begin
      sum_reg <= sum_reg + in_data;
    end
  end
`endif

  // Next-state selection for the load sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (load_req) begin
          state_next = (len_sat == '0) ? S_AFTER : S_RECV;
        end
      end
      S_RECV: begin
        if (word_ready) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = last_word ? S_AFTER : S_RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_next = (in_data == sum_reg) ? S_DONE : S_ERR;
        end
      end
      S_ERR: begin
        if (load_req) begin
          state_next = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Length latch and word pointer. ptr wraps naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg <= '0;
      ptr_reg <= '0;
    end else if (load_go) begin
      len_reg <= len_sat;
      ptr_reg <= '0;
    end else if (state_reg == S_WRITE) begin
      ptr_reg <= ptr_reg + ADDR_W'(1);
    end
  end

  // Sticky completion flag: set as cpu_start fires, cleared by a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
    end else if (load_go) begin
      done_reg <= 1'b0;
    end else if (state_reg == S_DONE) begin
      done_reg <= 1'b1;
    end
  end

  // Keep the last written address and data visible after the write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_hold_reg <= '0;
      wd_hold_reg  <= '0;
    end else if (state_reg == S_WRITE) begin
      adr_hold_reg <= ptr_reg;
      wd_hold_reg  <= packed_word;
    end
  end

  assign imem_we   = (state_reg == S_WRITE);
  assign imem_adr  = imem_we ? ptr_reg : adr_hold_reg;
  assign imem_wd   = imem_we ? packed_word : wd_hold_reg;
  assign cpu_start = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready  = (state_reg == S_RECV) || (state_reg == S_CHK);
  assign err       = (state_reg == S_ERR);
`else
  assign in_ready  = (state_reg == S_RECV);
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader. The stimulus pushes the expected
// events (memory writes, cpu_start, err entry) into a queue. A monitor pops
// that queue and checks each event as the DUT produces it, including its
// latency from the last accepted byte or load request.
`timescale 1ns/1ps
module tb_imem_program_loader;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_req = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_adr;
  logic [WIDTH-1:0]  imem_wd;
  logic              cpu_start;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  imem_program_loader #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .load_len (load_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .imem_we  (imem_we),
    .imem_adr (imem_adr),
    .imem_wd  (imem_wd),
    .cpu_start(cpu_start),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  localparam int EV_WRITE = 0;
  localparam int EV_START = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int          kind;
    int          adr;
    logic [31:0] wd;
    int          lat;
  } ev_t;

  ev_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ref_cyc = 0;
  logic        err_q = 1'b0;
  logic [31:0] img[0:DEPTH-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  task automatic observe(input int kind, input int adr, input logic [31:0] wd);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d adr %0d data 0x%08h, required no event", kind, adr, wd);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(kind), 64'(e.kind));
    if (e.kind == EV_WRITE) begin
      check("imem_adr", 64'(adr), 64'(e.adr));
      check("imem_wd", 64'(wd), 64'(e.wd));
    end
    check("event_latency", 64'(cyc - ref_cyc), 64'(e.lat));
    $display("txn kind=%0d adr=%0d data=0x%08h cycle=%0d", kind, adr, wd, cyc);
  endtask

  // Monitor: samples shortly after the falling edge, when both the DUT outputs
  // and the bench-driven inputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (imem_we) observe(EV_WRITE, int'(imem_adr), imem_wd);
        if (cpu_start) observe(EV_START, 0, 32'h0);
        if (err && !err_q) observe(EV_ERR, 0, 32'h0);
        if (in_valid && in_ready) ref_cyc = cyc;
        if (load_req && !busy) ref_cyc = cyc;
      end
      err_q = err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic start_load(input int len);
    load_len = (ADDR_W + 1)'(len);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 200 cycles, required 1");
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Full load. If poke >= 0, a load_req with len 5 is pulsed after that byte.
  task automatic run_image(input int len_req, input int nwords, input int gap, input int poke);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    int         idx = 0;
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back('{EV_WRITE, i % DEPTH, img[i], 1});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_q.push_back('{EV_START, 0, 32'h0, 1});
`else
    exp_q.push_back('{EV_START, 0, 32'h0, (nwords == 0) ? 1 : 2});
`endif
    start_load(len_req);
    check("busy_after_load", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        sum = sum + b;
        send_byte(b, gap);
        if (idx == poke) begin
          in_valid = 1'b0;
          start_load(5);
        end
        idx++;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sum, gap);
`endif
    in_valid = 1'b0;
    drain("load_events_drained");
    check("done_sticky", 64'(done), 64'd1);
    check("idle_after_load", 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_imem_we", 64'(imem_we), 64'd0);
    check("reset_imem_adr", 64'(imem_adr), 64'd0);
    check("reset_imem_wd", 64'(imem_wd), 64'd0);
    check("reset_flags", 64'({cpu_start, busy, done, err, in_ready}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two-word program, in_valid held high.
    img[0] = 32'h00500013;
    img[1] = 32'h00100093;
    run_image(2, 2, 0, -1);

    // Same image, in_valid toggling between bytes.
    run_image(2, 2, 1, -1);

    // Reset in the middle of the second word.
    exp_q.push_back('{EV_WRITE, 0, 32'h00500013, 1});
    start_load(2);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    drain("partial_load_events");
    #3 rst = 1'b1;
    #1;
    check("midreset_imem_we", 64'(imem_we), 64'd0);
    check("midreset_imem_adr", 64'(imem_adr), 64'd0);
    check("midreset_imem_wd", 64'(imem_wd), 64'd0);
    check("midreset_flags", 64'({cpu_start, busy, done, err, in_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    img[0] = 32'hDEADBEEF;
    run_image(1, 1, 0, -1);

    // Zero-length load: cpu_start with no write.
    run_image(0, 0, 0, -1);

    // Oversized length saturates to the full memory depth.
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = {8'(i), 8'(~i), 8'(i + 3), 8'(i * 7)};
    end
    run_image(200, DEPTH, 0, -1);

    // load_req while busy is ignored.
    img[0] = 32'h00500013;
    img[1] = 32'h00100093;
    run_image(2, 2, 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good trailer.
    img[0] = 32'h04030201;
    run_image(1, 1, 0, -1);

    // Bad trailer: err raised, no cpu_start, cleared by the next load_req.
    exp_q.push_back('{EV_WRITE, 0, 32'h04030201, 1});
    exp_q.push_back('{EV_ERR, 0, 32'h0, 1});
    start_load(1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h0B, 0);
    in_valid = 1'b0;
    drain("err_events_drained");
    check("err_set", 64'(err), 64'd1);
    check("err_no_done", 64'(done), 64'd0);
    start_load(0);
    check("err_cleared", 64'(err), 64'd0);
    check("err_exit_idle", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time stage directly upstream of the single-cycle CPU.
- Accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instruction words.
- Writes each word into the 128-word instruction memory, then pulses the CPU `start` input once the image is complete.
- Holds the CPU idle until a full program is resident.

Parameters:
- WIDTH, 32: instruction word width. Must be a multiple of 8.
- ADDR_W, 7: instruction memory address width. Matches the 7-bit PC.
- DEPTH, 128: number of instruction words. Equals 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_req  in  1  start a load; sampled only in IDLE
- load_len  in  ADDR_W+1  word count, latched on load_req; values above DEPTH saturate to DEPTH
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction memory write enable
- imem_adr  out  ADDR_W  instruction memory write address
- imem_wd  out  WIDTH  instruction memory write data
- cpu_start  out  1  one-cycle pulse to the CPU `start` input
- busy  out  1  high in every state except IDLE
- done  out  1  sticky; set on cpu_start, cleared by an accepted load_req
- err  out  1  checksum failure (see Optional Feature)

Behaviour:
- Reset: asynchronous and active-high.
  - All outputs go to 0; FSM goes to IDLE.
  - Word pointer, byte counter, packing register and running sum are cleared.
  - A partial word is discarded. Words already written to memory are not erased.
- A byte is transferred only on a cycle where in_valid and in_ready are both high.
- in_ready is high only in RECV (and in CHK when that state is compiled in). It does not depend combinationally on in_valid.
- Byte packing is little-endian: byte k of a word goes to bits [8k+7:8k], k = 0..3.
- FSM states: IDLE, RECV, WRITE, CHK (optional), DONE, ERR (optional).
  - IDLE → on load_req:
    - Latch the saturated length.
    - Clear ptr, byte counter, sum and done.
    - If length = 0, go to DONE; otherwise go to RECV.
  - RECV → WRITE when the 4th byte of a word is accepted.
  - WRITE, one cycle:
    - imem_we = 1, imem_adr = ptr, imem_wd = packed word.
    - Then ptr increments.
    - If this was the last word, go to DONE (or CHK when compiled in); otherwise go to RECV.
  - DONE, one cycle: cpu_start = 1, done set, then go to IDLE.
- imem_adr and imem_wd are valid only while imem_we is high; they hold their last value otherwise.
- Latency: last byte accepted → imem_we 1 cycle later → cpu_start 2 cycles later.
- Bytes offered while not in RECV/CHK are not accepted, since in_ready is low.
- load_req outside IDLE is ignored.
- When length = DEPTH, ptr wraps from DEPTH-1 back to 0 at the end. No extra write occurs.
- in_valid dropping mid-word stalls the FSM indefinitely with no timeout; the partial word is held.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running 8-bit modular sum of all accepted data bytes.
  - After the last WRITE it enters CHK and accepts one trailer byte.
  - Trailer equal to the sum → DONE.
  - Trailer not equal to the sum → ERR: err = 1, no cpu_start, done stays 0.
  - ERR exits to IDLE on load_req, which clears err.
  - For length = 0, the trailer must equal 0x00.
- Undefined: no CHK or ERR state, err tied to 0, no trailer byte is expected.

Decomposition:
- Package imem_loader_pkg holds:
  - The state enum (IDLE, RECV, WRITE, CHK, DONE, ERR).
  - Constants DEPTH, ADDR_W, and BYTES_PER_WORD = WIDTH/8.
- One sub-module, byte_packer:
  - Shift/insert register plus 2-bit byte counter.
  - Outputs word_ready and word.
  - Has a clear input driven by the FSM.

Test Plan:
- Two-word load: load_len = 2, bytes 13 00 50 00 93 00 10 00 with in_valid held high → imem writes 0x00500013 @0 and 0x00100093 @1; cpu_start pulses exactly once, 2 cycles after the last byte; done = 1.
- Back-pressure / valid gaps: same image with in_valid toggling every other cycle → identical writes and addresses; no byte is duplicated or dropped.
- Reset mid-word: assert rst after 2 bytes of word 1 → all outputs 0 immediately; a new load of len 1 with 0xDEADBEEF writes @0 only.
- Length boundaries:
  - load_len = 0 → cpu_start 1 cycle after load_req, no imem_we.
  - load_len = 200 → exactly 128 writes, addresses 0..127.
- load_req while busy: pulse load_req mid-RECV with load_len = 5 → ignored; the original length completes.
- Checksum (macro on):
  - Image 01 02 03 04 with trailer 0x0A → cpu_start.
  - Same image with trailer 0x0B → err = 1, no cpu_start; a subsequent load_req clears err.
